// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage: alu_op codes, RV32I opcodes and the
// decoded issue packet handed from the decoder to the skid buffer.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_OR   = 4'b0101,
    ALU_AND  = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    alu_op_e     alu_op;
    logic [4:0]  rd_addr;
    logic        rd_wren;
    logic        illegal;
  } issue_pkt_t;

  // alt selects SUB for funct3=000 and SRA for funct3=101
  function automatic alu_op_e funct3_to_op(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    op = ALU_ADD;
    case (funct3)
      3'b000: op = alt ? ALU_SUB : ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = alt ? ALU_SRA : ALU_SRL;
      3'b110: op = ALU_OR;
      3'b111: op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational RV32I ALU-class decoder. With ALU_ISSUE_FWD_EN defined, a
// write-back bypass overrides the register-file read data before selection.
module alu_decoder
  import alu_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
`ifdef ALU_ISSUE_FWD_EN
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_data_i,
`endif
  output issue_pkt_t  pkt_o
);

  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [2:0]  funct3;

`ifdef ALU_ISSUE_FWD_EN
  assign rs1_val = (wb_valid_i && (wb_rd_i != 5'd0) && (wb_rd_i == instr_i[19:15])) ? wb_data_i : rs1_data_i;
  assign rs2_val = (wb_valid_i && (wb_rd_i != 5'd0) && (wb_rd_i == instr_i[24:20])) ? wb_data_i : rs2_data_i;
`else
  assign rs1_val = rs1_data_i;
  assign rs2_val = rs2_data_i;
`endif

  assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_u  = {instr_i[31:12], 12'b0};
  assign funct3 = instr_i[14:12];

  always_comb begin
    pkt_o         = '0;
    pkt_o.alu_op  = ALU_ADD;
    pkt_o.rd_addr = instr_i[11:7];
    case (instr_i[6:0])
      OPC_OP: begin
        pkt_o.operand_a = rs1_val;
        pkt_o.operand_b = rs2_val;
        pkt_o.alu_op    = funct3_to_op(funct3, instr_i[30]);
      end
      OPC_OP_IMM: begin
        pkt_o.operand_a = rs1_val;
        // instr[30] is an immediate bit except on right shifts, so it only picks SRAI
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          pkt_o.operand_b = {27'b0, instr_i[24:20]};
          pkt_o.alu_op    = funct3_to_op(funct3, (funct3 == 3'b101) && instr_i[30]);
        end else begin
          pkt_o.operand_b = imm_i;
          pkt_o.alu_op    = funct3_to_op(funct3, 1'b0);
        end
      end
      OPC_LUI: begin
        pkt_o.operand_b = imm_u;
      end
      OPC_AUIPC: begin
        pkt_o.operand_a = pc_i;
        pkt_o.operand_b = imm_u;
      end
      default: begin
        pkt_o.illegal = 1'b1;
      end
    endcase
    pkt_o.rd_wren = !pkt_o.illegal && (instr_i[11:7] != 5'd0);
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decoder feeding a two-entry skid buffer with registered
// in_ready. Optional write-back forwarding ports under ALU_ISSUE_FWD_EN.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] operand_a,
  output logic [XLEN-1:0] operand_b,
  output logic [3:0]      alu_op,
  output logic [4:0]      rd_addr,
  output logic            rd_wren,
  output logic            illegal
`ifdef ALU_ISSUE_FWD_EN
  ,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data
`endif
);

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} skid_state_e;

  skid_state_e state_q, state_d;
  issue_pkt_t  main_q, main_d;
  issue_pkt_t  skid_q, skid_d;
  logic        in_ready_q, in_ready_d;
  issue_pkt_t  dec_pkt;
  logic        accept;
  logic        drain;

  alu_decoder u_decoder (
    .instr_i    (instr),
    .pc_i       (pc),
    .rs1_data_i (rs1_data),
    .rs2_data_i (rs2_data),
`ifdef ALU_ISSUE_FWD_EN
    .wb_valid_i (wb_valid),
    .wb_rd_i    (wb_rd),
    .wb_data_i  (wb_data),
`endif
    .pkt_o      (dec_pkt)
  );

  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = in_ready_q;
  assign accept    = in_valid && in_ready_q;
  assign drain     = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    // A beat accepted during flush is simply never written anywhere
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d  = dec_pkt;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_d = dec_pkt;
          end else if (accept) begin
            skid_d  = dec_pkt;
            state_d = ST_TWO;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (drain) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign operand_a = main_q.operand_a;
  assign operand_b = main_q.operand_b;
  assign alu_op    = main_q.alu_op;
  assign rd_addr   = main_q.rd_addr;
  assign rd_wren   = main_q.rd_wren;
  assign illegal   = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage: decode vectors, skid
// buffer back-pressure, flush and asynchronous reset.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] instr, pc, rs1_data, rs2_data, operand_a, operand_b;
  logic [3:0]  alu_op;
  logic [4:0]  rd_addr;
  logic        rd_wren, illegal;
`ifdef ALU_ISSUE_FWD_EN
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = 5'd0;
  logic [31:0] wb_data = 32'd0;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] instr, pc, rs1, rs2, a, b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        wren, ill;
  } vec_t;

  logic [76:0] got, exp;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .operand_a(operand_a), .operand_b(operand_b), .alu_op(alu_op),
    .rd_addr(rd_addr), .rd_wren(rd_wren), .illegal(illegal)
`ifdef ALU_ISSUE_FWD_EN
    , .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
`endif
  );

  // Drives one beat and returns 1 time unit after the accepting edge
  task automatic drive_beat(input vec_t v);
    instr = v.instr; pc = v.pc; rs1_data = v.rs1; rs2_data = v.rs2;
    in_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    instr = 32'd0; pc = 32'd0; rs1_data = 32'd0; rs2_data = 32'd0;
    step(); step();
    got = {out_valid, in_ready, operand_a, operand_b, alu_op, rd_addr, rd_wren, illegal};
    exp = {1'b0, 1'b1, 75'd0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_state got=%h exp=%h", got, exp); end
    else $display("reset: out_valid=0 in_ready=1 fields zero");
    rst = 1'b0;
    step();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL reset_release got=%b exp=01", {out_valid, in_ready});
    end
  endtask

  task automatic test_op();
    vec_t v[6];
    v[0] = '{32'h002081B3, 32'h0, 32'd5, 32'd7, 32'd5, 32'd7, 4'b0000, 5'd3, 1'b1, 1'b0};
    v[1] = '{32'h402081B3, 32'h0, 32'd5, 32'd7, 32'd5, 32'd7, 4'b0001, 5'd3, 1'b1, 1'b0};
    v[2] = '{32'h0020E1B3, 32'h0, 32'hF0, 32'h0F, 32'hF0, 32'h0F, 4'b0101, 5'd3, 1'b1, 1'b0};
    v[3] = '{32'h4020D1B3, 32'h0, 32'h80000000, 32'd4, 32'h80000000, 32'd4, 4'b1001, 5'd3, 1'b1, 1'b0};
    v[4] = '{32'h0020B1B3, 32'h0, 32'd9, 32'd2, 32'd9, 32'd2, 4'b0011, 5'd3, 1'b1, 1'b0};
    v[5] = '{32'h00208033, 32'h0, 32'd1, 32'd2, 32'd1, 32'd2, 4'b0000, 5'd0, 1'b0, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_beat(v[i]);
      got = {out_valid, in_ready, operand_a, operand_b, alu_op, rd_addr, rd_wren, illegal};
      exp = {1'b1, 1'b1, v[i].a, v[i].b, v[i].op, v[i].rd, v[i].wren, v[i].ill};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL op[%0d] instr=%h got=%h exp=%h", i, v[i].instr, got, exp); end
      else $display("op[%0d] instr=%h a=%h b=%h alu_op=%b rd=%0d wren=%b", i, v[i].instr, operand_a, operand_b, alu_op, rd_addr, rd_wren);
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL op_drain out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_imm();
    vec_t v[9];
    v[0] = '{32'hFFF00093, 32'h0, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 4'b0000, 5'd1, 1'b1, 1'b0};
    v[1] = '{32'h40335293, 32'h0, 32'h80000000, 32'hDEADBEEF, 32'h80000000, 32'd3, 4'b1001, 5'd5, 1'b1, 1'b0};
    v[2] = '{32'h00335293, 32'h0, 32'h80000000, 32'hDEADBEEF, 32'h80000000, 32'd3, 4'b1000, 5'd5, 1'b1, 1'b0};
    v[3] = '{32'h00331293, 32'h0, 32'h1, 32'hDEADBEEF, 32'h1, 32'd3, 4'b0111, 5'd5, 1'b1, 1'b0};
    v[4] = '{32'h123453B7, 32'h40, 32'h11111111, 32'h22222222, 32'h0, 32'h12345000, 4'b0000, 5'd7, 1'b1, 1'b0};
    v[5] = '{32'h00001297, 32'h100, 32'h33, 32'h44, 32'h100, 32'h1000, 4'b0000, 5'd5, 1'b1, 1'b0};
    v[6] = '{32'h8000C193, 32'h0, 32'h0000FFFF, 32'h0, 32'h0000FFFF, 32'hFFFFF800, 4'b0100, 5'd3, 1'b1, 1'b0};
    v[7] = '{32'h4000F193, 32'h0, 32'h7, 32'h0, 32'h7, 32'h400, 4'b0110, 5'd3, 1'b1, 1'b0};
    v[8] = '{32'h40008193, 32'h0, 32'h7, 32'h0, 32'h7, 32'h400, 4'b0000, 5'd3, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive_beat(v[i]);
      got = {out_valid, in_ready, operand_a, operand_b, alu_op, rd_addr, rd_wren, illegal};
      exp = {1'b1, 1'b1, v[i].a, v[i].b, v[i].op, v[i].rd, v[i].wren, v[i].ill};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL imm[%0d] instr=%h got=%h exp=%h", i, v[i].instr, got, exp); end
      else $display("imm[%0d] instr=%h a=%h b=%h alu_op=%b rd=%0d wren=%b", i, v[i].instr, operand_a, operand_b, alu_op, rd_addr, rd_wren);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_illegal();
    vec_t v[3];
    v[0] = '{32'h00000073, 32'h44, 32'hAAAA, 32'hBBBB, 32'h0, 32'h0, 4'b0000, 5'd0, 1'b0, 1'b1};
    v[1] = '{32'h00000183, 32'h48, 32'hAAAA, 32'hBBBB, 32'h0, 32'h0, 4'b0000, 5'd3, 1'b0, 1'b1};
    v[2] = '{32'h000000EF, 32'h4C, 32'hAAAA, 32'hBBBB, 32'h0, 32'h0, 4'b0000, 5'd1, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_beat(v[i]);
      got = {out_valid, in_ready, operand_a, operand_b, alu_op, rd_addr, rd_wren, illegal};
      exp = {1'b1, 1'b1, v[i].a, v[i].b, v[i].op, v[i].rd, v[i].wren, v[i].ill};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL illegal[%0d] instr=%h got=%h exp=%h", i, v[i].instr, got, exp); end
      else $display("illegal[%0d] instr=%h illegal=%b wren=%b", i, v[i].instr, illegal, rd_wren);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [33:0] g;
    logic [33:0] e [6];
    // {out_valid, in_ready, operand_a} after each edge
    e[0] = {1'b1, 1'b1, 32'd1};
    e[1] = {1'b1, 1'b0, 32'd1};
    e[2] = {1'b1, 1'b0, 32'd1};
    e[3] = {1'b1, 1'b1, 32'd2};
    e[4] = {1'b1, 1'b1, 32'd3};
    e[5] = {1'b0, 1'b1, 32'd3};
    out_ready = 1'b0;
    instr = 32'h002081B3; pc = 32'h0; rs2_data = 32'd0;
    for (int i = 0; i < 6; i++) begin
      if (i < 3) rs1_data = i + 1;
      in_valid = (i < 5);
      out_ready = (i >= 3);
      if (i == 4) in_valid = 1'b1;
      step();
      if (i == 4) in_valid = 1'b0;
      g = {out_valid, in_ready, operand_a};
      checks++;
      if (g !== e[i]) begin errors++; $display("FAIL b2b[%0d] got valid/ready/a=%h exp=%h", i, g, e[i]); end
      else $display("b2b[%0d] out_valid=%b in_ready=%b a=%h", i, out_valid, in_ready, operand_a);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h002081B3; rs2_data = 32'd0;
    rs1_data = 32'h11; step();
    rs1_data = 32'h22; step();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_fill in_ready got=%b exp=0", in_ready); end
    rs1_data = 32'h33; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL flush_empty valid/ready got=%b exp=01", {out_valid, in_ready});
    end else $display("flush: out_valid=0 in_ready=1");
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_stale[%0d] out_valid got=%b exp=0", i, out_valid); end
    end
    in_valid = 1'b1; rs1_data = 32'h44;
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, operand_a} !== {1'b1, 32'h44}) begin
      errors++; $display("FAIL flush_next got valid=%b a=%h exp valid=1 a=00000044", out_valid, operand_a);
    end else $display("flush: next beat a=%h", operand_a);
    step();
  endtask

  task automatic test_rst_mid();
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h002081B3; rs2_data = 32'd0;
    rs1_data = 32'h55; step();
    rs1_data = 32'h66; step();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, in_ready, operand_a} !== {1'b0, 1'b1, 32'h0}) begin
      errors++; $display("FAIL rst_async got valid=%b ready=%b a=%h exp 0/1/0", out_valid, in_ready, operand_a);
    end else $display("rst mid-stream: cleared asynchronously");
    step();
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
        errors++; $display("FAIL rst_stale[%0d] valid/ready got=%b exp=01", i, {out_valid, in_ready});
      end
    end
  endtask

  initial begin
    test_reset();
    test_op();
    test_imm();
    test_illegal();
    test_back_to_back();
    test_flush();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
